// File: rtl/alu_pkg.sv
// Shared types and default sizing for the ALU operation driver and its command FIFO.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StConfirm,
    StWait,
    StResp
  } drv_state_e;

  typedef struct packed {
    alu_op_e    op;
    logic [1:0] a;
    logic [1:0] b;
  } alu_cmd_t;

  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned DefaultResultLat = 2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; a push while full is dropped, even if a pop happens in the same cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned Depth = DefaultFifoDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  alu_cmd_t               wdata,
  input  logic                   pop,
  output alu_cmd_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  alu_cmd_t         mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// Queues ALU commands and sequences each through setup, confirm strobe, fixed-latency wait and a
// held response, keeping at most one operation outstanding at the ALU.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned RESULT_LAT = DefaultResultLat
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_b,
  output logic       handshaking,
  output logic       confirm_op,
  output logic [1:0] switch_op,
  output logic [1:0] operand_a,
  output logic [1:0] operand_b,
  input  logic [1:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_result,
  output logic [1:0] rsp_op,
  output logic       busy
);

  localparam int unsigned CntW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(RESULT_LAT - 1);

  drv_state_e                     state;
  logic [CntW-1:0]                wait_cnt;
  alu_cmd_t                       cmd_in;
  alu_cmd_t                       fifo_head;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;

  always_comb begin
    cmd_in    = '0;
    cmd_in.op = alu_op_e'(cmd_op);
    cmd_in.a  = cmd_a;
    cmd_in.b  = cmd_b;
  end

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  // The head is consumed exactly when the FSM loads a new command into the ALU operands.
  assign fifo_pop  = !fifo_empty &&
                     ((state == StIdle) || ((state == StResp) && rsp_ready));
  assign busy      = (state != StIdle) || (fifo_count != '0);

  alu_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (cmd_in),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      wait_cnt    <= '0;
      handshaking <= 1'b0;
      confirm_op  <= 1'b0;
      switch_op   <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
    end else begin
      confirm_op <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!fifo_empty) begin
            switch_op   <= fifo_head.op;
            operand_a   <= fifo_head.a;
            operand_b   <= fifo_head.b;
            handshaking <= 1'b1;
            state       <= StSetup;
          end
        end
        StSetup: begin
          confirm_op <= 1'b1;
          state      <= StConfirm;
        end
        StConfirm: begin
          wait_cnt <= '0;
          state    <= StWait;
        end
        StWait: begin
          if (wait_cnt == WaitLast) begin
            rsp_result <= alu_result;
            rsp_op     <= switch_op;
            rsp_valid  <= 1'b1;
            state      <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!fifo_empty) begin
              switch_op <= fifo_head.op;
              operand_a <= fifo_head.a;
              operand_b <= fifo_head.b;
              state     <= StSetup;
            end else begin
              handshaking <= 1'b0;
              state       <= StIdle;
            end
          end
        end
        default: begin
          handshaking <= 1'b0;
          state       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver: a latency-accurate ALU model drives alu_result, expected
// responses are queued at command acceptance and popped by an independent response monitor.
module tb_alu_op_driver;
  import alu_pkg::*;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned ResultLat = 2;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic       handshaking;
  logic       confirm_op;
  logic [1:0] switch_op;
  logic [1:0] operand_a;
  logic [1:0] operand_b;
  logic [1:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_result;
  logic [1:0] rsp_op;
  logic       busy;

  logic       rand_mode = 1'b0;
  logic       rand_rdy  = 1'b1;
  logic       fixed_rdy = 1'b1;

  int   n_vec     = 0;
  int   n_err     = 0;
  int   n_confirm = 0;
  int   n_rsp     = 0;
  exp_t exp_q[$];

  assign rsp_ready = rand_mode ? rand_rdy : fixed_rdy;

  always #5 clk = ~clk;

  alu_op_driver #(
    .FIFO_DEPTH (FifoDepth),
    .RESULT_LAT (ResultLat)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .handshaking (handshaking),
    .confirm_op  (confirm_op),
    .switch_op   (switch_op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .busy        (busy)
  );

  // Reference 2-bit ALU: integer arithmetic reduced modulo 4.
  function automatic logic [1:0] ref_alu(input logic [1:0] op, input logic [1:0] a,
                                         input logic [1:0] b);
    int r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 4;
      2'd1:    r = (int'(a) - int'(b) + 4) % 4;
      2'd2:    r = int'(a | b);
      default: r = int'(a & b);
    endcase
    return r[1:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ALU model: garbage until RESULT_LAT cycles after the confirm cycle, then the true result.
  initial begin : alu_model
    logic [1:0] r;
    alu_result = 2'b00;
    forever begin
      @(negedge clk);
      if (confirm_op) begin
        r          = ref_alu(switch_op, operand_a, operand_b);
        alu_result = ~r;
        repeat (ResultLat) @(negedge clk);
        alu_result = r;
      end
    end
  end

  initial begin : rand_ready_gen
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  logic prev_conf = 1'b0;
  always @(negedge clk) begin : confirm_checker
    if (!reset && confirm_op) begin
      n_confirm++;
      check("confirm_width", prev_conf, 8'd0);
      check("confirm_during_rsp", rsp_valid, 8'd0);
    end
    prev_conf = confirm_op;
  end

  logic       held_v = 1'b0;
  logic [1:0] held_res;
  logic [1:0] held_op;
  always @(negedge clk) begin : rsp_monitor
    exp_t e;
    if (reset) begin
      held_v = 1'b0;
    end else if (rsp_valid) begin
      if (held_v) begin
        check("rsp_hold_result", rsp_result, held_res);
        check("rsp_hold_op", rsp_op, held_op);
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_op", rsp_op, e.op);
          n_rsp++;
        end
        held_v = 1'b0;
      end else begin
        held_v   = 1'b1;
        held_res = rsp_result;
        held_op  = rsp_op;
      end
    end else begin
      if (held_v) fail("rsp_dropped_without_handshake");
      held_v = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one command; the expected response is queued on the cycle it is actually accepted.
  task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    int   tries = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        e.op  = op;
        e.res = ref_alu(op, a, b);
        exp_q.push_back(e);
        step(1);
        break;
      end
      tries++;
      if (tries > 200) begin
        fail("cmd_accept_timeout");
        step(1);
        break;
      end
      step(1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (t < 500) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
      t++;
    end
    if (t >= 500) fail("drain_timeout");
    step(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    int rsp0;
    int conf0;
    int t;
    int seen_valid;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 2'b00;
    cmd_b     = 2'b00;
    step(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 8'd1);
    check("reset_busy", busy, 8'd0);
    check("reset_handshaking", handshaking, 8'd0);
    check("reset_confirm", confirm_op, 8'd0);
    check("reset_rsp_valid", rsp_valid, 8'd0);
    check("reset_switch_op", switch_op, 8'd0);
    check("reset_operands", {operand_a, operand_b}, 8'd0);
    check("reset_rsp", {rsp_result, rsp_op}, 8'd0);
    step(1);

    // Single add with exact latency: confirm in the cycle after E+2, rsp_valid after E+5
    send(2'b00, 2'b11, 2'b11);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lat_confirm", confirm_op, (k == 2) ? 8'd1 : 8'd0);
      check("lat_rsp_valid", rsp_valid, (k == 5) ? 8'd1 : 8'd0);
      check("lat_handshaking", handshaking, (k >= 1) ? 8'd1 : 8'd0);
    end
    step(1);
    drain();

    // Back-to-back sub/or/and
    conf0 = n_confirm;
    rsp0  = n_rsp;
    send(2'b01, 2'b11, 2'b01);
    send(2'b10, 2'b01, 2'b10);
    send(2'b11, 2'b11, 2'b10);
    drain();
    check("b2b_confirm_count", 8'(n_confirm - conf0), 8'd3);
    check("b2b_rsp_count", 8'(n_rsp - rsp0), 8'd3);

    // Back-pressure: 1 in flight + 4 queued fills the driver
    rsp0      = n_rsp;
    fixed_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    check("bp_cmd_ready_full", cmd_ready, 8'd0);
    check("bp_busy", busy, 8'd1);
    step(8);
    // Full FIFO: release the response and offer a push in the same cycle; the push must be refused
    fixed_rdy = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_a     = 2'b01;
    cmd_b     = 2'b00;
    @(negedge clk);
    check("full_pop_no_bypass", cmd_ready, 8'd0);
    check("full_pop_rsp_valid", rsp_valid, 8'd1);
    step(1);
    send(2'b10, 2'b01, 2'b00);
    drain();
    check("bp_rsp_count", 8'(n_rsp - rsp0), 8'd6);

    // Reset during WAIT with two commands queued
    send(2'b00, 2'b01, 2'b10);
    send(2'b01, 2'b00, 2'b01);
    send(2'b11, 2'b11, 2'b11);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!confirm_op && t < 20);
    if (t >= 20) fail("wait_confirm_timeout");
    step(1);
    reset = 1'b1;
    exp_q.delete();
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_handshaking", handshaking, 8'd0);
    check("rst_cmd_ready", cmd_ready, 8'd1);
    check("rst_busy", busy, 8'd0);
    check("rst_confirm", confirm_op, 8'd0);
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid || confirm_op) seen_valid++;
    end
    check("rst_no_activity", 8'(seen_valid), 8'd0);
    step(1);
    rsp0 = n_rsp;
    send(2'b00, 2'b01, 2'b01);
    drain();
    check("post_rst_rsp_count", 8'(n_rsp - rsp0), 8'd1);

    // Randomised traffic with random response back-pressure
    rsp0      = n_rsp;
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 2));
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    rand_mode = 1'b0;
    fixed_rdy = 1'b1;
    drain();
    check("rand_rsp_count", 8'(n_rsp - rsp0), 8'd80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth; power of two, 2 or more.
REQ-002 Parameter RESULT_LAT, default 2, cycles from the confirm_op cycle's end to a valid alu_result.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  queue can accept a command.
REQ-007 cmd_op  in  2  operation code: 00 add, 01 sub, 10 or, 11 and.
REQ-008 cmd_a, cmd_b  in  2 each  operands.
REQ-009 handshaking  out  1  ALU session active.
REQ-010 confirm_op  out  1  one-cycle execute strobe to the ALU FSM.
REQ-011 switch_op  out  2  operation to the ALU.
REQ-012 operand_a, operand_b  out  2 each  operands to the ALU.
REQ-013 alu_result  in  2  ALU result.
REQ-014 rsp_valid  out  1  result available.
REQ-015 rsp_ready  in  1  result consumer ready.
REQ-016 rsp_result  out  2  captured alu_result.
REQ-017 rsp_op  out  2  operation code the result belongs to.
REQ-018 busy  out  1  high in every state except IDLE, or while the FIFO is non-empty.

Function
REQ-019 Push on a cycle with cmd_valid && cmd_ready; cmd_ready = (count < FIFO_DEPTH).
  - cmd_ready does not rise early on a pop in the same cycle (no full bypass).
  - Commands leave the FIFO in FIFO order.
REQ-020 FSM states IDLE, SETUP, CONFIRM, WAIT, RESP.
REQ-021 IDLE, FIFO non-empty: pop the head, load switch_op/operand_a/operand_b, go to SETUP; otherwise stay in IDLE.
REQ-022 SETUP: handshaking=1, operands stable, confirm_op=0; go to CONFIRM after 1 cycle.
REQ-023 CONFIRM: confirm_op=1 for exactly 1 cycle; go to WAIT.
REQ-024 WAIT: confirm_op=0; stay exactly RESULT_LAT cycles.
  - On the WAIT exit edge: capture alu_result into rsp_result and switch_op into rsp_op; go to RESP.
REQ-025 handshaking=1 in SETUP, CONFIRM, WAIT and RESP; 0 in IDLE.
  - switch_op/operand_a/operand_b stay unchanged from SETUP entry until the next pop.
REQ-026 RESP: rsp_valid=1, with rsp_result/rsp_op stable until rsp_valid && rsp_ready.
  - On that handshake: if the FIFO is non-empty, pop and go to SETUP; else go to IDLE.
REQ-027 Latency: command accepted at edge E into an empty FIFO with the FSM in IDLE -> confirm_op high during the cycle after E+2 -> rsp_valid first high after edge E+3+RESULT_LAT (edge E+5 at default).
REQ-028 confirm_op never asserts while rsp_valid=1; one ALU operation is outstanding at most.
REQ-029 The FIFO continues accepting while RESP is stalled by rsp_ready=0, up to full.
REQ-030 The block performs no arithmetic; rsp_result is the raw 2-bit alu_result (wrap-around is the ALU's).

Reset
REQ-031 While reset=1 at a clock edge, the following are all 0 on the next cycle: state = IDLE, FIFO emptied, WAIT counter cleared, handshaking, confirm_op, switch_op, operand_a, operand_b, rsp_valid, rsp_result, rsp_op, busy; cmd_ready = 1.
REQ-032 Reset mid-operation, in any state: the in-flight and queued commands are discarded with no rsp_valid; confirm_op is 0 from the cycle after the reset edge.

Structure
REQ-033 Shared package alu_pkg holds:
  - alu_op_e (OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_AND=2'b11);
  - drv_state_e;
  - the alu_cmd_t struct {op, a, b};
  - the default constants for FIFO_DEPTH and RESULT_LAT.
REQ-034 One sub-module, alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push, pop, full, empty and count; the FSM stays in alu_op_driver.

Verification
REQ-035 The bench connects a behavioural 2-bit ALU model with latency RESULT_LAT; a checker flags any confirm_op pulse wider than 1 cycle or any confirm_op pulse while rsp_valid=1.
REQ-036 Add: op=00, a=11, b=11, rsp_ready=1 -> confirm_op pulses 1 cycle; rsp_valid after edge E+5; rsp_result=10, rsp_op=00.
REQ-037 Back-to-back: push sub(11,01), or(01,10), and(11,10) on consecutive cycles -> results 10, 11, 10 in order; exactly three confirm_op pulses.
REQ-038 Back-pressure: rsp_ready=0, push 6 commands -> cmd_ready drops after the FIFO holds 4; the first result is held stable; releasing rsp_ready delivers all results in order.
REQ-039 Reset in WAIT with 2 commands queued -> no rsp_valid, handshaking=0 next cycle, cmd_ready=1; a new add(01,01) afterwards returns 10.
REQ-040 Full with simultaneous pop: FIFO full, RESP handshake with a cmd_valid push in the same cycle -> the push is refused (cmd_ready=0) and no command is lost or duplicated.
